// File: rtl/act_pingpong_buffer.sv
// Double-buffered activation store: the producer fills one bank while the consumer
// reads the other, and ownership swaps on wr_last / rd_done handshakes.
module act_pingpong_buffer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int ROW_LSB  = 3,
  parameter int ROW_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int MEM_DEPTH = 2 ** (ROW_BITS + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_state_e;

  bank_state_e       state_r     [2];
  bank_state_e       state_nxt_s [2];
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic              err_ovf_r;
  logic              err_udf_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  logic                wr_ready_s;
  logic                rd_ready_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                swap_wr_s;
  logic                swap_rd_s;
  logic [ROW_BITS-1:0] wr_idx_s;
  logic [ROW_BITS-1:0] rd_idx_s;
  logic                unused_addr_s;

  assign wr_idx_s      = wr_addr[ROW_LSB +: ROW_BITS];
  assign rd_idx_s      = rd_addr[ROW_LSB +: ROW_BITS];
  assign unused_addr_s = ^{wr_addr, rd_addr};

  assign wr_ready_s = (state_r[wr_bank_r] == ST_EMPTY) || (state_r[wr_bank_r] == ST_FILLING);
  assign rd_ready_s = (state_r[rd_bank_r] == ST_FULL)  || (state_r[rd_bank_r] == ST_READING);
  assign wr_acc_s   = wr_en   && wr_ready_s;
  assign rd_acc_s   = rd_en   && rd_ready_s;
  assign swap_wr_s  = wr_last && wr_ready_s;
  assign swap_rd_s  = rd_done && rd_ready_s;

  // Per-bank next state; a bank is never producer-ready and consumer-ready at once.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_nxt_s[b] = state_r[b];
      if (wr_ready_s && (wr_bank_r == 1'(b))) begin
        if (wr_last) begin
          state_nxt_s[b] = ST_FULL;
        end else if (wr_en) begin
          state_nxt_s[b] = ST_FILLING;
        end else begin
          state_nxt_s[b] = state_r[b];
        end
      end else if (rd_ready_s && (rd_bank_r == 1'(b))) begin
        if (rd_done) begin
          state_nxt_s[b] = ST_EMPTY;
        end else if (rd_en) begin
          state_nxt_s[b] = ST_READING;
        end else begin
          state_nxt_s[b] = state_r[b];
        end
      end else begin
        state_nxt_s[b] = state_r[b];
      end
    end
  end

  // Bank states, ownership pointers and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r[0] <= ST_EMPTY;
      state_r[1] <= ST_EMPTY;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      err_ovf_r  <= 1'b0;
      err_udf_r  <= 1'b0;
    end else begin
      state_r[0] <= state_nxt_s[0];
      state_r[1] <= state_nxt_s[1];
      wr_bank_r  <= wr_bank_r ^ swap_wr_s;
      rd_bank_r  <= rd_bank_r ^ swap_rd_s;
      err_ovf_r  <= err_ovf_r | ((wr_en | wr_last) & ~wr_ready_s);
      err_udf_r  <= err_udf_r | ((rd_en | rd_done) & ~rd_ready_s);
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[{wr_bank_r, wr_idx_s}] <= wr_data;
    end
  end

  // Registered read port: data held between reads, valid for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_acc_s) begin
      rd_data_r  <= mem_r[{rd_bank_r, rd_idx_s}];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign wr_ready = wr_ready_s;
  assign rd_ready = rd_ready_s;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign wr_bank  = wr_bank_r;
  assign rd_bank  = rd_bank_r;
  assign err_ovf  = err_ovf_r;
  assign err_udf  = err_udf_r;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Directed bench for act_pingpong_buffer: expected read data is queued at issue time
// and a negedge monitor pops it whenever rd_valid is seen.
module tb_act_pingpong_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_done;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_bank;
  logic        rd_bank;
  logic        err_ovf;
  logic        err_udf;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];

  act_pingpong_buffer #(
    .DATA_W(16), .ADDR_W(16), .ROW_LSB(3), .ROW_BITS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one accepted read and queue its expected data.
  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input logic done);
    rd_en   = 1'b1;
    rd_addr = addr;
    rd_done = done;
    exp_q.push_back(exp);
    tick;
    rd_en   = 1'b0;
    rd_done = 1'b0;
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h, expected no read", rd_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = 16'h0000; rd_done = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Reset / idle state
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_wr_bank",  wr_bank,  1'b0);
    chk("rst_rd_bank",  rd_bank,  1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_err_ovf",  err_ovf,  1'b0);
    chk("rst_err_udf",  err_udf,  1'b0);

    // Underflow: read with nothing to read
    rd_en = 1'b1; rd_addr = 16'h0000;
    tick;
    rd_en = 1'b0;
    chk("udf_err_udf",  err_udf,  1'b1);
    chk("udf_rd_valid", rd_valid, 1'b0);
    chk("udf_err_ovf",  err_ovf,  1'b0);

    // Fill bank 0; the last write shares its cycle with wr_last
    for (int i = 0; i < 256; i++) begin
      if (i == 128) chk("fill0_rd_ready", rd_ready, 1'b0);
      wr_en = 1'b1; wr_addr = 16'(i << 3); wr_data = 16'h1000 + 16'(i);
      wr_last = (i == 255);
      tick;
    end
    wr_en = 1'b0; wr_last = 1'b0;
    chk("swap0_wr_bank",  wr_bank,  1'b1);
    chk("swap0_rd_ready", rd_ready, 1'b1);
    chk("swap0_wr_ready", wr_ready, 1'b1);
    chk("swap0_rd_bank",  rd_bank,  1'b0);

    // Back-to-back reads of bank 0
    rd(16'h0038, 16'h1007, 1'b0);
    rd(16'h07F8, 16'h10FF, 1'b0);
    rd(16'h0000, 16'h1000, 1'b0);

    // Fill bank 1 while bank 0 is being read; index 1 written via aliasing address
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = (i == 1) ? 16'h0808 : 16'(i << 3);
      wr_data = 16'h2000 + 16'(i); wr_last = (i == 255);
      if (i == 0) begin
        rd_en = 1'b1; rd_addr = 16'h0010;
        exp_q.push_back(16'h1002);
      end
      tick;
      rd_en = 1'b0;
    end
    wr_en = 1'b0; wr_last = 1'b0;
    chk("both_full_wr_ready", wr_ready, 1'b0);
    chk("both_full_wr_bank",  wr_bank,  1'b0);

    // Overflow: write while both banks are full
    wr_en = 1'b1; wr_addr = 16'h0000; wr_data = 16'hDEAD;
    tick;
    wr_en = 1'b0;
    chk("ovf_err_ovf",  err_ovf,  1'b1);
    chk("ovf_wr_ready", wr_ready, 1'b0);

    // Consumer releases bank 0
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    chk("done_rd_bank",  rd_bank,  1'b1);
    chk("done_wr_ready", wr_ready, 1'b1);
    chk("done_wr_bank",  wr_bank,  1'b0);
    chk("done_rd_ready", rd_ready, 1'b1);

    rd(16'h0008, 16'h2001, 1'b0);
    rd(16'h1808, 16'h2001, 1'b0);
    rd(16'h07F8, 16'h20FF, 1'b0);

    // Simultaneous wr_last (empty bank 0) and rd_done (bank 1)
    wr_last = 1'b1; rd_done = 1'b1;
    tick;
    wr_last = 1'b0; rd_done = 1'b0;
    chk("sim_wr_bank",  wr_bank,  1'b1);
    chk("sim_rd_bank",  rd_bank,  1'b0);
    chk("sim_wr_ready", wr_ready, 1'b1);
    chk("sim_rd_ready", rd_ready, 1'b1);

    // Bank 0 must still hold the pre-overflow value; last read carries rd_done
    rd(16'h0000, 16'h1000, 1'b0);
    rd(16'h0040, 16'h1008, 1'b1);
    tick;
    chk("rddone_rd_bank",  rd_bank,  1'b1);
    chk("rddone_rd_ready", rd_ready, 1'b0);
    chk("rddone_wr_ready", wr_ready, 1'b1);
    chk("sticky_err_udf",  err_udf,  1'b1);
    chk("sticky_err_ovf",  err_ovf,  1'b1);

    // Make bank 1 readable, accept a read, then reset before the data is consumed
    wr_last = 1'b1;
    tick;
    wr_last = 1'b0;
    chk("pre_rst_rd_ready", rd_ready, 1'b1);
    chk("pre_rst_wr_bank",  wr_bank,  1'b0);
    rd_en = 1'b1; rd_addr = 16'h0000;
    tick;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_rd_ready", rd_ready, 1'b0);
    chk("midrst_wr_ready", wr_ready, 1'b1);
    chk("midrst_wr_bank",  wr_bank,  1'b0);
    chk("midrst_rd_bank",  rd_bank,  1'b0);
    chk("midrst_err_ovf",  err_ovf,  1'b0);
    chk("midrst_err_udf",  err_udf,  1'b0);
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk("post_rst_rd_ready", rd_ready, 1'b0);
    chk("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
